// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between two requesters
// (port 0 = cpu core, port 1 = loader/DMA). Round-robin, one transaction
// in flight, fixed wait-state count for slow memory.
//
// Ports:
//   clock, reset        system clock (rising edge), async active-low reset
//   reqN/rwN/addrN/wdataN  requester N: request (hold until ackN),
//                       direction (1 = read), address, write data
//   ackN                one-cycle completion pulse for requester N
//   rdata               read data of the acked port; holds otherwise
//   gnt                 one-hot owner, 00 when idle
//   busy                transaction in ACCESS or DONE
//   mem_addr/mem_wdata/mem_rw/mem_rdata  external memory port
//
// Optional: define MEM_BUS_ARBITER_LOCK_EN to add lock0/lock1. An owner
// holding its lock through DONE keeps the bus for its next request.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
`ifdef MEM_BUS_ARBITER_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state, state_n;
  logic [1:0]          gnt_n;
  logic                ack0_n, ack1_n;
  logic [DATA_W-1:0]   rdata_n, mem_wdata_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic                mem_rw_n;
  logic                last, last_n;   // port that won the previous grant
  logic [3:0]          cnt, cnt_n;
  logic                win;
`ifdef MEM_BUS_ARBITER_LOCK_EN
  logic                lock_flag, lock_flag_n;  // owner is 'last'
`endif

  // busy decodes straight from the state register: no req-to-output path
  assign busy = (state != IDLE);

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    rdata_n     = rdata;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_rw_n    = mem_rw;
    last_n      = last;
    cnt_n       = cnt;
    win         = 1'b0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    lock_flag_n = lock_flag;
`endif
    case (state)
      IDLE: begin
`ifdef MEM_BUS_ARBITER_LOCK_EN
        // flag survives only by being honoured; DONE re-arms it
        lock_flag_n = 1'b0;
`endif
        if (req0 || req1) begin
          win = (req0 && req1) ? ~last : req1;
`ifdef MEM_BUS_ARBITER_LOCK_EN
          if (lock_flag && (last ? (req1 && lock1) : (req0 && lock0)))
            win = last;
`endif
          mem_rw_n    = win ? rw1    : rw0;
          mem_addr_n  = win ? addr1  : addr0;
          mem_wdata_n = win ? wdata1 : wdata0;
          gnt_n       = win ? 2'b10  : 2'b01;
          last_n      = win;
          cnt_n       = WAIT_INIT;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (mem_rw) rdata_n = mem_rdata;
          // ack is registered on entry to DONE so it is high for all of DONE
          ack0_n  = gnt[0];
          ack1_n  = gnt[1];
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
`ifdef MEM_BUS_ARBITER_LOCK_EN
        lock_flag_n = gnt[1] ? lock1 : lock0;
`endif
        gnt_n   = 2'b00;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b1;
      last      <= 1'b1;
      cnt       <= 4'd0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
      lock_flag <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
      rdata     <= rdata_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_rw    <= mem_rw_n;
      last      <= last_n;
      cnt       <= cnt_n;
`ifdef MEM_BUS_ARBITER_LOCK_EN
      lock_flag <= lock_flag_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, rw0 = 1, req1 = 0, rw1 = 1;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic        ack0, ack1, busy, mem_rw;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  gnt;
`ifdef MEM_BUS_ARBITER_LOCK_EN
  logic        lock0 = 0, lock1 = 0;
`endif

  // second/third instances for the WAIT_CYCLES = 0 / 15 latency checks
  logic        x_req[2];
  logic        x_ack0[2], x_ack1[2], x_busy[2], x_mrw[2];
  logic [31:0] x_rdata[2], x_maddr[2], x_mwdata[2];
  logic [1:0]  x_gnt[2];

  int total = 0, bad = 0;
  logic [31:0] last_rd = 0;

  typedef struct { logic port; logic [31:0] rd; } exp_t;
  exp_t q[$];

  typedef struct { logic port; logic rw; logic [31:0] addr; logic [31:0] wdata; } vec_t;
  vec_t tbl[6];

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  mem_bus_arbiter #(.WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
`ifdef MEM_BUS_ARBITER_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata));

  mem_bus_arbiter #(.WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset(reset),
    .req0(x_req[0]), .rw0(1'b1), .addr0(32'h40), .wdata0(32'h0),
    .req1(1'b0), .rw1(1'b1), .addr1(32'h0), .wdata1(32'h0),
`ifdef MEM_BUS_ARBITER_LOCK_EN
    .lock0(1'b0), .lock1(1'b0),
`endif
    .ack0(x_ack0[0]), .ack1(x_ack1[0]), .rdata(x_rdata[0]), .gnt(x_gnt[0]),
    .busy(x_busy[0]), .mem_addr(x_maddr[0]), .mem_wdata(x_mwdata[0]),
    .mem_rw(x_mrw[0]), .mem_rdata(32'hCAFE_0000));

  mem_bus_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .clock(clock), .reset(reset),
    .req0(x_req[1]), .rw0(1'b1), .addr0(32'h40), .wdata0(32'h0),
    .req1(1'b0), .rw1(1'b1), .addr1(32'h0), .wdata1(32'h0),
`ifdef MEM_BUS_ARBITER_LOCK_EN
    .lock0(1'b0), .lock1(1'b0),
`endif
    .ack0(x_ack0[1]), .ack1(x_ack1[1]), .rdata(x_rdata[1]), .gnt(x_gnt[1]),
    .busy(x_busy[1]), .mem_addr(x_maddr[1]), .mem_wdata(x_mwdata[1]),
    .mem_rw(x_mrw[1]), .mem_rdata(32'hCAFE_000F));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // scoreboard: every ack pops the next expected {port, rdata}
  always @(negedge clock) begin
    if (ack0 && ack1) chk("ack_overlap", 32'd1, 32'd0);
    if (ack0 || ack1) begin
      if (q.size() == 0) chk("unexpected_ack", {ack1, ack0}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
        chk("ack_rdata", rdata, e.rd);
      end
    end
  end

  task automatic push_exp(input logic p, input logic rw, input logic [31:0] a);
    exp_t e;
    e.port = p;
    e.rd   = rw ? mem_fn(a) : last_rd;
    if (rw) last_rd = e.rd;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 0; req1 = 0; rw0 = 1; rw1 = 1;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    x_req[0] = 0; x_req[1] = 0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    lock0 = 0; lock1 = 0;
`endif
    last_rd = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // single transaction: grant, latched payload, stability, latency, release
  task automatic xfer(input vec_t v);
    int k;
    bit got;
    push_exp(v.port, v.rw, v.addr);
    if (v.port) begin req1 = 1; rw1 = v.rw; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1; rw0 = v.rw; addr0 = v.addr; wdata0 = v.wdata; end
    @(negedge clock);
    chk("gnt", gnt, v.port ? 2'b10 : 2'b01);
    chk("busy", busy, 1);
    chk("mem_addr", mem_addr, v.addr);
    chk("mem_rw", mem_rw, v.rw);
    chk("mem_wdata", mem_wdata, v.wdata);
    // payload changes after grant must not reach the memory port
    if (v.port) begin rw1 = ~v.rw; addr1 = ~v.addr; wdata1 = ~v.wdata; end
    else        begin rw0 = ~v.rw; addr0 = ~v.addr; wdata0 = ~v.wdata; end
    k = 1; got = 0;
    while (!got && k < 40) begin
      @(negedge clock);
      k++;
      if (ack0 || ack1) got = 1;
      else begin
        chk("hold_addr", mem_addr, v.addr);
        chk("hold_wdata", mem_wdata, v.wdata);
        chk("hold_rw", mem_rw, v.rw);
      end
    end
    chk("ack_latency", k, 3);
    req0 = 0; req1 = 0;
    @(negedge clock);
    chk("gnt_after", gnt, 2'b00);
    chk("busy_after", busy, 0);
    chk("ack_after", {ack1, ack0}, 2'b00);
  endtask

  task automatic lat(input int i, input int w, input logic [31:0] rd);
    int k;
    bit got;
    x_req[i] = 1; k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clock);
      k++;
      if (x_ack0[i]) got = 1;
      if (k == 2) x_req[i] = 0;   // requester drops req at t+2
    end
    chk($sformatf("lat_w%0d", w), k, w + 2);
    chk($sformatf("rdata_w%0d", w), x_rdata[i], rd);
    x_req[i] = 0;
    repeat (2) @(negedge clock);
    chk($sformatf("idle_w%0d", w), x_gnt[i], 2'b00);
  endtask

  initial begin
    logic [1:0] prev;
    int gi, na;
    logic ord[4];

    tbl[0] = '{port: 1'b0, rw: 1'b1, addr: 32'h10,       wdata: 32'h0};
    tbl[1] = '{port: 1'b1, rw: 1'b0, addr: 32'h20,       wdata: 32'h12345678};
    tbl[2] = '{port: 1'b0, rw: 1'b0, addr: 32'h24,       wdata: 32'hA5A5_F00D};
    tbl[3] = '{port: 1'b1, rw: 1'b1, addr: 32'h44,       wdata: 32'h0};
    tbl[4] = '{port: 1'b1, rw: 1'b1, addr: 32'h10,       wdata: 32'hFFFF_FFFF};
    tbl[5] = '{port: 1'b0, rw: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h1};

    x_req[0] = 0; x_req[1] = 0;
    repeat (2) @(negedge clock);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rw", mem_rw, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) xfer(tbl[i]);

    // both requesters held: grants must alternate starting with port 0
    do_reset();
    ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1;
    for (int i = 0; i < 4; i++) push_exp(ord[i], 1'b1, ord[i] ? 32'h200 : 32'h100);
    req0 = 1; rw0 = 1; addr0 = 32'h100;
    req1 = 1; rw1 = 1; addr1 = 32'h200;
    prev = 2'b00; gi = 0; na = 0;
    for (int c = 0; c < 80 && na < 4; c++) begin
      @(negedge clock);
      if (prev == 2'b00 && gnt != 2'b00) begin
        if (gi < 4) chk("rr_order", gnt, ord[gi] ? 2'b10 : 2'b01);
        gi++;
      end
      prev = gnt;
      if (ack0 || ack1) na++;
    end
    req0 = 0; req1 = 0;
    chk("rr_acks", na, 4);
    repeat (2) @(negedge clock);
    chk("rr_idle", gnt, 2'b00);

    // reset in the middle of ACCESS aborts with no ack
    do_reset();
    req0 = 1; rw0 = 1; addr0 = 32'h30;
    @(negedge clock);
    chk("abort_pre_gnt", gnt, 2'b01);
    reset = 1'b0;
    #1;
    chk("abort_gnt", gnt, 2'b00);
    chk("abort_busy", busy, 0);
    chk("abort_mem_rw", mem_rw, 1);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_ack", {ack1, ack0}, 2'b00);
    req0 = 0;
    @(negedge clock);
    reset = 1'b1;
    last_rd = 0;
    repeat (3) @(negedge clock);
    chk("abort_rdata", rdata, 0);
    xfer(tbl[0]);

    lat(0, 0, 32'hCAFE_0000);
    lat(1, 15, 32'hCAFE_000F);

`ifdef MEM_BUS_ARBITER_LOCK_EN
    // lock1 keeps port 1 on the bus for 3 transfers, then round-robin resumes
    do_reset();
    ord[0] = 1; ord[1] = 1; ord[2] = 1; ord[3] = 0;
    for (int i = 0; i < 4; i++) push_exp(ord[i], 1'b1, ord[i] ? 32'h50 : 32'h60);
    lock1 = 1; req1 = 1; rw1 = 1; addr1 = 32'h50;
    prev = 2'b00; gi = 0; na = 0;
    for (int c = 0; c < 100 && na < 4; c++) begin
      @(negedge clock);
      if (prev == 2'b00 && gnt != 2'b00) begin
        if (gi < 4) chk("lock_order", gnt, ord[gi] ? 2'b10 : 2'b01);
        gi++;
        if (gi == 1) begin req0 = 1; rw0 = 1; addr0 = 32'h60; end
        if (gi == 3) lock1 = 0;
      end
      prev = gnt;
      if (ack0 || ack1) na++;
    end
    req0 = 0; req1 = 0;
    chk("lock_acks", na, 4);
    repeat (2) @(negedge clock);
`endif

    repeat (2) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
